// File: rtl/alu_pkg.sv
// Shared encodings for the ALU: funct3 operation selects, funct7 variant
// selects and the shift-amount width used by the barrel shifter.
package alu_pkg;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_AND     = 3'b010;
    localparam logic [2:0] F3_OR      = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_SLT     = 3'b110;
    localparam logic [2:0] F3_SLTU    = 3'b111;

    // funct7 picks add vs sub under F3_ADD_SUB and logical vs arithmetic under F3_SR
    localparam logic F7_BASE = 1'b0;
    localparam logic F7_ALT  = 1'b1;

    localparam int SHAMT_W = 5;

endpackage

// File: rtl/alu_shifter.sv
// Log-stage barrel shifter. Left shifts reuse the right-shift stages by
// bit-reversing the operand on the way in and on the way out.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir,
    input  logic               arith,
    output logic [WIDTH-1:0]   out
);

    logic             fill;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] stage;

    assign fill = dir & arith & a[WIDTH-1];

    always_comb begin
        src = '0;
        for (int j = 0; j < WIDTH; j++) begin
            src[j] = dir ? a[j] : a[WIDTH-1-j];
        end
    end

    // Stage i shifts right by 2**i, pulling fill bits in from the top
    always_comb begin
        stage = src;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (shamt[i]) begin
                stage = WIDTH'({{WIDTH{fill}}, stage} >> (1 << i));
            end
        end
    end

    always_comb begin
        out = '0;
        for (int j = 0; j < WIDTH; j++) begin
            out[j] = dir ? stage[j] : stage[WIDTH-1-j];
        end
    end

endmodule

// File: rtl/alu.sv
// Single-cycle ALU with a combinational result and an enable-gated register
// stage holding the result and its zero/negative/carry/overflow flags.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic [2:0]       funct3,
    input  logic             funct7,
    input  logic             en,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_q,
    output logic             zero_q,
    output logic             neg_q,
    output logic             carry_q,
    output logic             ovf_q
);

    logic             isSub;
    logic [WIDTH-1:0] bEff;
    logic [WIDTH-1:0] sum;
    logic             carryOut;
    logic             addOvf;
    logic [WIDTH-1:0] shiftOut;
    logic             shiftRight;
    logic             shiftArith;
    logic             ltSigned;
    logic             ltUnsigned;
    logic             carry;
    logic             ovf;
    logic             zero;
    logic             neg;

    // One adder serves both add and sub: subtract is A + ~B + 1
    assign isSub = (funct7 == F7_ALT);
    assign bEff  = isSub ? ~operandB : operandB;
    assign {carryOut, sum} = {1'b0, operandA} + {1'b0, bEff} + {{WIDTH{1'b0}}, isSub};
    assign addOvf = (operandA[WIDTH-1] == bEff[WIDTH-1]) && (sum[WIDTH-1] != operandA[WIDTH-1]);

    assign shiftRight = (funct3 == F3_SR);
    assign shiftArith = (funct7 == F7_ALT);

    alu_shifter #(
        .WIDTH(WIDTH)
    ) shifter (
        .a    (operandA),
        .shamt(operandB[SHAMT_W-1:0]),
        .dir  (shiftRight),
        .arith(shiftArith),
        .out  (shiftOut)
    );

    assign ltSigned   = $signed(operandA) < $signed(operandB);
    assign ltUnsigned = operandA < operandB;

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (funct3)
            F3_ADD_SUB: begin
                result = sum;
                carry  = carryOut;
                ovf    = addOvf;
            end
            F3_SLL:  result = shiftOut;
            F3_AND:  result = operandA & operandB;
            F3_OR:   result = operandA | operandB;
            F3_XOR:  result = operandA ^ operandB;
            F3_SR:   result = shiftOut;
            F3_SLT:  result = {{(WIDTH-1){1'b0}}, ltSigned};
            F3_SLTU: result = {{(WIDTH-1){1'b0}}, ltUnsigned};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);
    assign neg  = result[WIDTH-1];

    // Reset clears the capture stage asynchronously and overrides en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (en) begin
            result_q <= result;
            zero_q   <= zero;
            neg_q    <= neg;
            carry_q  <= carry;
            ovf_q    <= ovf;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed testbench for alu: hand-computed vectors for every operation,
// flag capture, enable hold and asynchronous reset behaviour.
module tb_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic [2:0]  funct3;
    logic        funct7;
    logic        en;
    logic [31:0] result;
    logic [31:0] result_q;
    logic        zero_q;
    logic        neg_q;
    logic        carry_q;
    logic        ovf_q;

    int vectors     = 0;
    int miscompares = 0;

    alu #(
        .WIDTH(32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .operandA(operandA),
        .operandB(operandB),
        .funct3  (funct3),
        .funct7  (funct7),
        .en      (en),
        .result  (result),
        .result_q(result_q),
        .zero_q  (zero_q),
        .neg_q   (neg_q),
        .carry_q (carry_q),
        .ovf_q   (ovf_q)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] f3, input logic f7, input logic e);
        @(negedge clk);
        operandA = a;
        operandB = b;
        funct3   = f3;
        funct7   = f7;
        en       = e;
        #1;
    endtask

    // Waits for the next rising edge and checks every registered output
    task automatic checkRegistered(input string tag, input logic [31:0] rq,
                                   input logic z, input logic n, input logic c, input logic o);
        @(posedge clk);
        #1;
        checkOutput({tag, ".result_q"}, result_q, rq);
        checkOutput({tag, ".zero_q"},   {31'b0, zero_q},  {31'b0, z});
        checkOutput({tag, ".neg_q"},    {31'b0, neg_q},   {31'b0, n});
        checkOutput({tag, ".carry_q"},  {31'b0, carry_q}, {31'b0, c});
        checkOutput({tag, ".ovf_q"},    {31'b0, ovf_q},   {31'b0, o});
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b1;
        operandA = 32'd10;
        operandB = 32'd20;
        funct3   = 3'b000;
        funct7   = 1'b0;
        #12;
        $display("[TB] reset state");
        checkOutput("rst.result_q", result_q, 32'd0);
        checkOutput("rst.zero_q",   {31'b0, zero_q},  32'd0);
        checkOutput("rst.carry_q",  {31'b0, carry_q}, 32'd0);
        checkOutput("rst.result",   result, 32'd30);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] add / sub");
        applyStimulus(32'd10, 32'd20, 3'b000, 1'b0, 1'b1);
        checkOutput("add", result, 32'd30);
        checkRegistered("add", 32'd30, 1'b0, 1'b0, 1'b0, 1'b0);

        applyStimulus(32'd50, 32'd30, 3'b000, 1'b1, 1'b1);
        checkOutput("sub", result, 32'd20);
        checkRegistered("sub", 32'd20, 1'b0, 1'b0, 1'b1, 1'b0);

        applyStimulus(32'h7FFF_FFFF, 32'd1, 3'b000, 1'b0, 1'b1);
        checkOutput("add_ovf", result, 32'h8000_0000);
        checkRegistered("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);

        applyStimulus(32'hFFFF_FFFF, 32'd1, 3'b000, 1'b0, 1'b1);
        checkOutput("add_carry", result, 32'd0);
        checkRegistered("add_carry", 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);

        applyStimulus(32'h8000_0000, 32'd1, 3'b000, 1'b1, 1'b1);
        checkOutput("sub_ovf", result, 32'h7FFF_FFFF);
        checkRegistered("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);

        applyStimulus(32'd3, 32'd5, 3'b000, 1'b1, 1'b1);
        checkOutput("sub_borrow", result, 32'hFFFF_FFFE);
        checkRegistered("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("[TB] shifts");
        applyStimulus(32'd8, 32'd2, 3'b001, 1'b1, 1'b0);
        checkOutput("sll", result, 32'd32);
        applyStimulus(32'd32, 32'd2, 3'b101, 1'b0, 1'b0);
        checkOutput("srl", result, 32'd8);
        applyStimulus(32'hFFFF_FFF0, 32'd2, 3'b101, 1'b1, 1'b0);
        checkOutput("sra", result, 32'hFFFF_FFFC);
        applyStimulus(32'hFFFF_FFF0, 32'd2, 3'b101, 1'b0, 1'b0);
        checkOutput("srl_neg", result, 32'h3FFF_FFFC);
        applyStimulus(32'h1234_5678, 32'hFFFF_FFE0, 3'b001, 1'b0, 1'b0);
        checkOutput("sll_zero", result, 32'h1234_5678);
        applyStimulus(32'h8765_4321, 32'hFFFF_FFE0, 3'b101, 1'b1, 1'b0);
        checkOutput("sra_zero", result, 32'h8765_4321);
        applyStimulus(32'h8000_0000, 32'h0000_003F, 3'b101, 1'b1, 1'b0);
        checkOutput("sra_31", result, 32'hFFFF_FFFF);
        applyStimulus(32'h0000_0001, 32'h0000_003F, 3'b001, 1'b0, 1'b0);
        checkOutput("sll_31", result, 32'h8000_0000);
        applyStimulus(32'hA5A5_0F0F, 32'h0000_0024, 3'b101, 1'b0, 1'b0);
        checkOutput("srl_4", result, 32'h0A5A_50F0);

        $display("[TB] logic and compares");
        applyStimulus(32'b10101, 32'b11011, 3'b010, 1'b0, 1'b0);
        checkOutput("and", result, 32'b10001);
        applyStimulus(32'b10101, 32'b11011, 3'b011, 1'b1, 1'b0);
        checkOutput("or", result, 32'b11111);
        applyStimulus(32'b10101, 32'b11011, 3'b100, 1'b0, 1'b1);
        checkOutput("xor", result, 32'b01110);
        checkRegistered("xor", 32'b01110, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 32'd1, 3'b110, 1'b0, 1'b0);
        checkOutput("slt", result, 32'd1);
        applyStimulus(32'hFFFF_FFFF, 32'd1, 3'b111, 1'b0, 1'b0);
        checkOutput("sltu", result, 32'd0);
        applyStimulus(32'd1, 32'hFFFF_FFFF, 3'b111, 1'b1, 1'b0);
        checkOutput("sltu_true", result, 32'd1);
        applyStimulus(32'd7, 32'hFFFF_FFFF, 3'b110, 1'b1, 1'b0);
        checkOutput("slt_false", result, 32'd0);

        $display("[TB] capture and hold");
        applyStimulus(32'd5, 32'd5, 3'b000, 1'b1, 1'b1);
        checkOutput("sub_eq", result, 32'd0);
        checkRegistered("sub_eq", 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(32'h7FFF_FFFF, 32'd1, 3'b000, 1'b0, 1'b0);
        checkRegistered("hold", 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(32'h7FFF_FFFF, 32'd1, 3'b000, 1'b0, 1'b1);
        checkRegistered("recapture", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);

        $display("[TB] asynchronous reset");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst.result_q", result_q, 32'd0);
        checkOutput("arst.neg_q",    {31'b0, neg_q}, 32'd0);
        checkOutput("arst.ovf_q",    {31'b0, ovf_q}, 32'd0);
        operandA = 32'd3;
        operandB = 32'd4;
        #1;
        checkOutput("arst.result", result, 32'd7);
        checkRegistered("arst_hold", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(32'd9, 32'd1, 3'b000, 1'b0, 1'b1);
        checkRegistered("post_rst", 32'd10, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; only WIDTH=32 SHALL be required to verify.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 operandA  input  WIDTH  first operand.
REQ-005 operandB  input  WIDTH  second operand; bits [4:0] are the shift amount for shift ops.
REQ-006 funct3  input  3  operation select.
REQ-007 funct7  input  1  variant select: sub for 000, arithmetic shift for 101.
REQ-008 en  input  1  capture enable for registered outputs.
REQ-009 result  output  WIDTH  combinational operation result.
REQ-010 result_q  output  WIDTH  registered copy of result.
REQ-011 zero_q, neg_q, carry_q, ovf_q  output  1 each  registered flags.

Function
REQ-012 result SHALL be purely combinational from operandA, operandB, funct3 and funct7, settling within the same cycle with no clock dependence.
REQ-013 funct3=000, funct7=0: result = A+B modulo 2^WIDTH.
REQ-014 funct3=000, funct7=1: result = A-B modulo 2^WIDTH (two's complement).
REQ-015 funct3=001: result = A << B[4:0], zero fill; funct7 ignored.
REQ-016 funct3=010: result = A & B; 011: A | B; 100: A ^ B; funct7 ignored.
REQ-017 funct3=101, funct7=0: result = A >> B[4:0], zero fill (logical).
REQ-018 funct3=101, funct7=1: result = A >>> B[4:0], sign-bit fill (arithmetic).
REQ-019 funct3=110: result = 1 if signed A < signed B else 0; 111: same, unsigned compare; funct7 ignored.
REQ-020 Shift amount 0 SHALL return A unchanged; B[WIDTH-1:5] SHALL be ignored for shifts.
REQ-021 carry: add = carry-out of A+B; sub = 1 when A >= B unsigned (no borrow); 0 for all other ops.
REQ-022 ovf: add/sub = signed overflow (operand signs per op agree and result sign differs); 0 for all other ops.
REQ-023 zero = (result == 0); neg = result[WIDTH-1]; valid for every op.
REQ-024 On rising clk with en=1: result_q, zero_q, neg_q, carry_q, ovf_q load current combinational values; en=0 holds them.
REQ-025 Registered outputs SHALL have one-cycle latency relative to inputs sampled at the capturing edge.

Reset
REQ-026 rst=1 SHALL immediately, independent of clk, clear result_q, zero_q, neg_q, carry_q, ovf_q to 0.
REQ-027 While rst=1, en SHALL be ignored; combinational result SHALL stay functional.
REQ-028 Reset asserted mid-operation SHALL discard any pending capture; first capture after release occurs on the next rising edge with en=1.

Structure
REQ-029 Package alu_pkg SHALL hold funct3 encoding constants (ADD_SUB, SLL, AND, OR, XOR, SR, SLT, SLTU) and the funct7 variant constants.
REQ-030 Barrel shifter SHALL be one sub-module, alu_shifter (A, shamt, dir, arith -> out); all other logic stays in alu.
REQ-031 Add and subtract SHALL share one adder (B inverted, carry-in 1 for sub).

Verification
REQ-032 A=10, B=20, 000/0 -> result=30, after en edge zero_q=0, carry_q=0, ovf_q=0.
REQ-033 A=50, B=30, 000/1 -> result=20, carry_q=1; A=0x7FFFFFFF, B=1, 000/0 -> result=0x80000000, ovf_q=1, neg_q=1.
REQ-034 A=8, B=2, 001 -> 32; A=32, B=2, 101/0 -> 8; A=0xFFFFFFF0, B=2, 101/1 -> 0xFFFFFFFC; 101/0 -> 0x3FFFFFFC.
REQ-035 A=0b10101, B=0b11011: 010 -> 0b10001, 011 -> 0b11111, 100 -> 0b01110; A=0xFFFFFFFF, B=1: 110 -> 1, 111 -> 0.
REQ-036 A=5, B=5, 000/1, en=1 edge -> result_q=0, zero_q=1; then en=0 with new inputs -> registered outputs hold.
REQ-037 Assert rst between clock edges with outputs nonzero -> all registered outputs 0 immediately; result still tracks inputs.
